// File: rtl/cpu_pkg.sv
// Shared definitions for the cycle-accurate CPU executor: FSM states,
// instruction encoding, datapath widths and the signal-strength sample cycles.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC1 = 2'd1,
      EXEC2 = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Instruction word: bit 8 is the opcode, bits 7:0 the signed immediate.
   localparam int INSTR_W = 9;
   localparam int IMM_W   = 8;
   localparam int OP_BIT  = 8;
   localparam logic OP_NOOP = 1'b0;
   localparam logic OP_ADDX = 1'b1;

   localparam int ADDR_W = 8;
   localparam int CYC_W  = 8;
   // Wide enough to compare against a PROG_LEN beyond the 8-bit address space.
   localparam int PC_W   = 16;
   localparam int PROD_W = 17;
   localparam int SUM_W  = 24;

   // Strength is sampled at cycles 20, 60, 100, 140, 180 and 220.
   localparam int NUM_SAMPLES  = 6;
   localparam int SAMPLE_FIRST = 20;
   localparam int SAMPLE_STEP  = 40;

   function automatic logic [CYC_W-1:0] sample_cycle(input int idx);
      return CYC_W'(SAMPLE_FIRST + SAMPLE_STEP * idx);
   endfunction

endpackage

// File: rtl/cpu_exec_strength_acc.sv
// Signal-strength accumulator: on an accepted beat at a sample cycle,
// adds cycle_idx * x to the running sum on the accepting clock edge.
module strength_acc
   import cpu_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fire,
   input  logic [CYC_W-1:0]        cycle_idx,
   input  logic signed [IMM_W-1:0] x,
   output logic signed [SUM_W-1:0] sum
);

   logic [NUM_SAMPLES-1:0]    hit;
   logic signed [PROD_W-1:0]  cyc_ext;
   logic signed [PROD_W-1:0]  x_ext;
   logic signed [PROD_W-1:0]  prod;
   logic signed [SUM_W-1:0]   sum_reg;

   // One comparator per sample cycle.
   generate
      for (genvar gi = 0; gi < NUM_SAMPLES; gi++) begin : g_sample
         assign hit[gi] = (cycle_idx == sample_cycle(gi));
      end
   endgenerate

   // cycle_idx is unsigned, so zero-extend it; x is sign-extended.
   assign cyc_ext = {{(PROD_W-CYC_W){1'b0}}, cycle_idx};
   assign x_ext   = {{(PROD_W-IMM_W){x[IMM_W-1]}}, x};
   assign prod    = cyc_ext * x_ext;

   // Accumulate the signed product on sampled, accepted beats.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sum_reg <= '0;
      end else if (fire && (|hit)) begin
         sum_reg <= sum_reg + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
      end
   end

   assign sum = sum_reg;

endmodule

// File: rtl/cpu_exec.sv
// Cycle-accurate executor for a noop/addx program: presents one X beat per
// CPU cycle over a valid/ready handshake and accumulates signal strength.
module cpu_exec
   import cpu_pkg::*;
#(
   parameter int PROG_LEN   = 146,
   parameter int MAX_CYCLES = 240
)
(
   input  logic                    clk,
   input  logic                    rst,
   output logic [ADDR_W-1:0]       imem_addr,
   input  logic [INSTR_W-1:0]      imem_data,
   output logic                    beat_valid,
   input  logic                    beat_ready,
   output logic signed [IMM_W-1:0] x_out,
   output logic [CYC_W-1:0]        cycle_idx,
   output logic signed [SUM_W-1:0] strength_sum,
   output logic                    done
);

   state_t                  state_reg, state_next;
   logic [PC_W-1:0]         pc_reg, pc_next, pc_inc;
   logic signed [IMM_W-1:0] x_reg, x_next;
   logic signed [IMM_W-1:0] imm_reg, imm_next;
   logic [CYC_W-1:0]        cyc_reg, cyc_next;
   logic                    fire;
   logic                    last_beat;
   logic                    prog_end;

   assign beat_valid = (state_reg == EXEC1) || (state_reg == EXEC2);
   assign fire       = beat_valid && beat_ready;
   assign pc_inc     = pc_reg + PC_W'(1);
   assign last_beat  = (cyc_reg == CYC_W'(MAX_CYCLES));
   assign prog_end   = (pc_inc == PC_W'(PROG_LEN));

   // Next-state and datapath updates; nothing moves unless a beat is accepted.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      x_next     = x_reg;
      imm_next   = imm_reg;
      cyc_next   = cyc_reg;
      case (state_reg)
         IDLE: begin
            state_next = (PROG_LEN == 0) ? DONE : EXEC1;
         end
         EXEC1: begin
            if (fire) begin
               cyc_next = cyc_reg + CYC_W'(1);
               if (imem_data[OP_BIT] == OP_ADDX) begin
                  // Immediate captured now so the second beat needs no fetch.
                  imm_next   = imem_data[IMM_W-1:0];
                  state_next = EXEC2;
               end else begin
                  pc_next    = pc_inc;
                  state_next = prog_end ? DONE : EXEC1;
               end
               if (last_beat) begin
                  state_next = DONE;
               end
            end
         end
         EXEC2: begin
            if (fire) begin
               cyc_next   = cyc_reg + CYC_W'(1);
               x_next     = x_reg + imm_reg;
               pc_next    = pc_inc;
               state_next = prog_end ? DONE : EXEC1;
               if (last_beat) begin
                  state_next = DONE;
               end
            end
         end
         default: begin
            state_next = DONE;
         end
      endcase
   end

   // State and datapath registers; reset also drops any pending addx.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         x_reg     <= IMM_W'(1);
         imm_reg   <= '0;
         cyc_reg   <= CYC_W'(1);
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         x_reg     <= x_next;
         imm_reg   <= imm_next;
         cyc_reg   <= cyc_next;
      end
   end

   assign imem_addr = pc_reg[ADDR_W-1:0];
   assign x_out     = x_reg;
   assign cycle_idx = cyc_reg;
   assign done      = (state_reg == DONE);

   strength_acc u_acc (
      .clk       (clk),
      .rst       (rst),
      .fire      (fire),
      .cycle_idx (cyc_reg),
      .x         (x_reg),
      .sum       (strength_sum)
   );

endmodule

// File: tb/tb_cpu_exec.sv
// Self-checking bench for cpu_exec: a short-program instance driven from a
// vector table, and a long-program instance for the multi-cycle sequences.
module tb_cpu_exec;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [8:0] mem [256];

   // Short program instance (PROG_LEN = 3)
   logic              rst_s, ready_s, valid_s, done_s;
   logic [7:0]        addr_s, cyc_s;
   logic [8:0]        data_s;
   logic signed [7:0] x_s;
   logic signed [23:0] sum_s;

   // Long program instance (PROG_LEN = 300)
   logic              rst_l, ready_l, valid_l, done_l;
   logic [7:0]        addr_l, cyc_l;
   logic [8:0]        data_l;
   logic signed [7:0] x_l;
   logic signed [23:0] sum_l;

   assign data_s = mem[addr_s];
   assign data_l = mem[addr_l];

   cpu_exec #(.PROG_LEN(3), .MAX_CYCLES(240)) u_short (
      .clk          (clk),
      .rst          (rst_s),
      .imem_addr    (addr_s),
      .imem_data    (data_s),
      .beat_valid   (valid_s),
      .beat_ready   (ready_s),
      .x_out        (x_s),
      .cycle_idx    (cyc_s),
      .strength_sum (sum_s),
      .done         (done_s)
   );

   cpu_exec #(.PROG_LEN(300), .MAX_CYCLES(240)) u_long (
      .clk          (clk),
      .rst          (rst_l),
      .imem_addr    (addr_l),
      .imem_data    (data_l),
      .beat_valid   (valid_l),
      .beat_ready   (ready_l),
      .x_out        (x_l),
      .cycle_idx    (cyc_l),
      .strength_sum (sum_l),
      .done         (done_l)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic ready;
      int   valid;
      int   cyc;
      int   x;
      int   addr;
      int   done;
   } vec_t;

   vec_t tbl [8];

   // Reset the long instance; returns at the negedge showing beat 1 in EXEC1.
   task automatic restart_long();
      rst_l   = 1'b0;
      ready_l = 1'b0;
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
   endtask

   task automatic show_long(input string tag);
      $display("%s: valid=%0d cycle=%0d x=%0d addr=%0d sum=%0d done=%0d",
               tag, valid_l, cyc_l, x_l, addr_l, sum_l, done_l);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats;

      // {noop; addx 3; addx -5} with ready held high
      tbl[0] = '{1'b1, 0, 1,  1, 0, 0};   // IDLE
      tbl[1] = '{1'b1, 1, 1,  1, 0, 0};   // noop
      tbl[2] = '{1'b1, 1, 2,  1, 1, 0};   // addx 3, beat 1
      tbl[3] = '{1'b1, 1, 3,  1, 1, 0};   // addx 3, beat 2
      tbl[4] = '{1'b1, 1, 4,  4, 2, 0};   // addx -5, beat 1
      tbl[5] = '{1'b1, 1, 5,  4, 2, 0};   // addx -5, beat 2
      tbl[6] = '{1'b1, 0, 6, -1, 3, 1};   // DONE
      tbl[7] = '{1'b1, 0, 6, -1, 3, 1};   // DONE held

      rst_s = 1'b0; ready_s = 1'b0;
      rst_l = 1'b0; ready_l = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 9'h000;
      mem[1] = {1'b1, 8'd3};
      mem[2] = {1'b1, 8'hFB};

      repeat (3) @(negedge clk);
      chk("reset sum", int'(sum_s), 0);
      chk("reset valid", int'(valid_s), 0);
      rst_s = 1'b1;
      for (int i = 0; i < 8; i++) begin
         $display("vec %0d: valid=%0d cycle=%0d x=%0d addr=%0d done=%0d",
                  i, valid_s, cyc_s, x_s, addr_s, done_s);
         chk($sformatf("vec%0d valid", i), int'(valid_s), tbl[i].valid);
         chk($sformatf("vec%0d cycle", i), int'(cyc_s), tbl[i].cyc);
         chk($sformatf("vec%0d x", i), int'(x_s), tbl[i].x);
         chk($sformatf("vec%0d addr", i), int'(addr_s), tbl[i].addr);
         chk($sformatf("vec%0d done", i), int'(done_s), tbl[i].done);
         ready_s = tbl[i].ready;
         @(negedge clk);
      end
      chk("short sum", int'(sum_s), 0);
      rst_s = 1'b0;

      // 300 noops: 240 beats, strength 720, sample at beat 20
      for (int i = 0; i < 256; i++) mem[i] = 9'h000;
      restart_long();
      ready_l = 1'b1;
      beats = 0;
      for (int n = 0; n < 400 && !done_l; n++) begin
         if (valid_l) begin
            beats++;
            chk("noop cycle", int'(cyc_l), beats);
            if (cyc_l == 8'd20) begin
               show_long("beat20");
               chk("beat20 x", int'(x_l), 1);
            end
            if (cyc_l == 8'd21) begin
               show_long("beat21");
               chk("sum after 20", int'(sum_l), 20);
            end
         end
         @(negedge clk);
      end
      show_long("end");
      chk("done after 240", int'(done_l), 1);
      chk("beat count", beats, 240);
      chk("final sum", int'(sum_l), 720);
      chk("valid in done", int'(valid_l), 0);
      @(negedge clk);
      chk("sum frozen", int'(sum_l), 720);
      chk("done held", int'(done_l), 1);

      // addx 3 stalled for 3 cycles in its second beat
      mem[0] = {1'b1, 8'd3};
      restart_long();
      ready_l = 1'b1;
      @(negedge clk);
      ready_l = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         show_long($sformatf("stall%0d", k));
         chk($sformatf("stall%0d valid", k), int'(valid_l), 1);
         chk($sformatf("stall%0d x", k), int'(x_l), 1);
         chk($sformatf("stall%0d cycle", k), int'(cyc_l), 2);
         chk($sformatf("stall%0d addr", k), int'(addr_l), 0);
      end
      ready_l = 1'b1;
      @(negedge clk);
      show_long("post stall");
      chk("post stall x", int'(x_l), 4);
      chk("post stall cycle", int'(cyc_l), 3);
      chk("post stall addr", int'(addr_l), 1);

      // reset while stalled in EXEC2
      restart_long();
      ready_l = 1'b1;
      @(negedge clk);
      ready_l = 1'b0;
      @(negedge clk);
      chk("pre reset cycle", int'(cyc_l), 2);
      rst_l = 1'b0;
      @(negedge clk);
      show_long("in reset");
      chk("rst valid", int'(valid_l), 0);
      chk("rst x", int'(x_l), 1);
      chk("rst cycle", int'(cyc_l), 1);
      chk("rst sum", int'(sum_l), 0);
      chk("rst addr", int'(addr_l), 0);
      chk("rst done", int'(done_l), 0);
      rst_l = 1'b1;
      ready_l = 1'b1;
      @(negedge clk);
      show_long("restart");
      chk("restart valid", int'(valid_l), 1);
      chk("restart cycle", int'(cyc_l), 1);
      chk("restart x", int'(x_l), 1);
      repeat (2) @(negedge clk);
      show_long("restart addx");
      chk("restart addx x", int'(x_l), 4);
      chk("restart addx cycle", int'(cyc_l), 3);

      // {addx 127; addx 127} wraps
      mem[0] = {1'b1, 8'd127};
      mem[1] = {1'b1, 8'd127};
      restart_long();
      ready_l = 1'b1;
      repeat (2) @(negedge clk);
      show_long("wrap1");
      chk("wrap1 x", int'(x_l), -128);
      chk("wrap1 cycle", int'(cyc_l), 3);
      repeat (2) @(negedge clk);
      show_long("wrap2");
      chk("wrap2 x", int'(x_l), -1);
      chk("wrap2 addr", int'(addr_l), 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
